// File: rtl/seq_divider.sv
// Restoring sequential divider: one quotient bit per cycle, signed/unsigned.
// Optional SEQ_DIVIDER_EARLY_OUT_EN: skip iterations when |divisor| > |dividend| or divisor is zero.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH:0] ONE1 = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  logic             eo_q, eo_d;
`endif

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   sh, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? ~dividend + ONE : dividend;
  assign dvs_abs = dvs_neg ? ~divisor + ONE : divisor;

  // prem < divisor keeps trial inside a signed WIDTH+1 range
  assign sh    = {prem_q, wq_q[WIDTH-1]};
  assign trial = sh + ~{1'b0, dvs_q} + ONE1;

  assign q_fix = qneg_q ? ~wq_q + ONE : wq_q;
  assign r_fix = rneg_q ? ~prem_q + ONE : prem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    eo_d    = eo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d   = dvs_abs;
          wq_d    = dvd_abs;
          prem_d  = '0;
          dvd_d   = dividend;
          qneg_d  = dvd_neg ^ dvs_neg;
          rneg_d  = dvd_neg;
          dz_d    = (divisor == '0);
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          eo_d = dvs_abs > dvd_abs;
          if (eo_d || dz_d) state_d = FIX;
`endif
        end
      end
      CALC: begin
        wq_d   = {wq_q[WIDTH-2:0], ~trial[WIDTH]};
        prem_d = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        dbz_d   = dz_q;
        state_d = IDLE;
        if (dz_q) begin
          quot_d = '1;
          rem_d  = dvd_q;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        end else if (eo_q) begin
          quot_d = '0;
          rem_d  = dvd_q;
`endif
        end else begin
          quot_d = q_fix;
          rem_d  = r_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      wq_q    <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
      eo_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      wq_q    <= wq_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
      eo_q    <= eo_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a queue scoreboard of expected results.
// Checks latency, results, div-by-zero flag, start blocking and async reset.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .signed_op(signed_op),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic res_t model(input logic [31:0] a, b, input logic s);
    res_t e;
    logic signed [31:0] sa, sb2;
    logic [31:0] aa, ab;
    sa = a;
    sb2 = b;
    e.lat = 33;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      e.q = sa / sb2;
      e.r = sa % sb2;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    aa = (s && a[31]) ? -a : a;
    ab = (s && b[31]) ? -b : b;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    if (b == 32'd0 || ab > aa) e.lat = 1;
`else
    if (aa == ab && ab == 32'd1) e.lat = 33;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, b, input logic s, input bit now);
    if (!now) @(negedge clk);
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b, s));
    #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input bit pulse);
    res_t e;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done !== 1'b1) begin
      chk("timeout", {31'd0, done}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("latency", cyc - acc_cyc, e.lat);
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("dbz", {31'd0, div_by_zero}, {31'd0, e.dz});
    chk("busy_done", {31'd0, busy}, 32'd0);
    if (pulse) begin
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'd100, 32'd7, 1'b0, 1'b0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    wait_done(1'b1);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_done(1'b1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_done(1'b1);
    issue(32'h1234_5678, 32'd0, 1'b0, 1'b0);
    wait_done(1'b1);
    issue(32'd6, 32'd3, 1'b0, 1'b0);
    wait_done(1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_done(1'b1);

    // start held through busy with changing operands
    @(negedge clk);
    dividend = 32'd100;
    divisor = 32'd7;
    signed_op = 1'b0;
    start = 1'b1;
    @(posedge clk);
    sb.push_back(model(32'd100, 32'd7, 1'b0));
    #1;
    acc_cyc = cyc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dividend = $urandom;
      divisor = $urandom;
      signed_op = ~signed_op;
    end
    start = 1'b0;
    wait_done(1'b1);

    // back-to-back start in the done cycle
    issue(32'd1000, 32'd10, 1'b0, 1'b0);
    wait_done(1'b0);
    issue(32'hFFFF_CFC7, 32'd67, 1'b1, 1'b1);
    chk("busy_b2b", {31'd0, busy}, 32'd1);
    wait_done(1'b1);

    issue(32'd5, 32'd9, 1'b0, 1'b0);
    wait_done(1'b1);

    for (int i = 0; i < 4; i++) begin
      issue($urandom, $urandom_range(1, 1000), i[0], 1'b0);
      wait_done(1'b1);
    end

    // async reset in the middle of CALC
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_q", quotient, 32'd0);
    chk("mid_r", remainder, 32'd0);
    chk("mid_dbz", {31'd0, div_by_zero}, 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_nodone", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      chk("post_rst_nodone", {31'd0, done}, 32'd0);
    end

    issue(32'd77, 32'd5, 1'b0, 1'b0);
    wait_done(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
